axi_mem_slave_v2: RTL and testbench

AXI4 memory slave with independent read and write engines that run concurrently, backed by a byte-addressed internal RAM. Supports FIXED, INCR and WRAP bursts, narrow transfers and registered (sequential) memory access. Reports SLVERR on out-of-range or illegal bursts. Used as a bus-attached scratch memory and as a bench target for AXI masters.

---
 rtl/axi_pkg.sv | 26 ++
 rtl/axi_burst_addr.sv | 39 +++
 rtl/axi_mem_slave_v2.sv | 249 ++++++++++++++++++++++++
 tb/tb_axi_mem_slave_v2.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI types for the memory slave: burst encodings, response codes and engine states.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  typedef logic [1:0] resp_t;
  localparam resp_t OKAY   = 2'b00;
  localparam resp_t SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } r_state_t;

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational AXI next-beat address calculator with illegal-burst detection.
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              illegal
);

  localparam int unsigned SIZE_MAX = $clog2(DATA_W / 8);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] wrap_bytes;
  logic [ADDR_W-1:0] wrap_low;
  logic [ADDR_W-1:0] incr_addr;
  logic              wrap_len_ok;

  always_comb begin
    step        = ADDR_W'(1) << size;
    wrap_bytes  = (ADDR_W'(len) + ADDR_W'(1)) * step;
    wrap_low    = addr & ~(wrap_bytes - ADDR_W'(1));
    incr_addr   = addr + step;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    next_addr   = addr;
    if (burst == INCR) begin
      next_addr = (addr & ~(step - ADDR_W'(1))) + step;
    end else if (burst == WRAP) begin
      next_addr = (incr_addr == wrap_low + wrap_bytes) ? wrap_low : incr_addr;
    end
    illegal = (burst == 2'b11) || (size > 3'(SIZE_MAX)) || ((burst == WRAP) && !wrap_len_ok);
  end

endmodule

// File: rtl/axi_mem_slave_v2.sv
// AXI4 memory slave: independent write and read engines over a byte-addressed RAM,
// with FIXED/INCR/WRAP bursts, narrow transfers and SLVERR on range or burst errors.
module axi_mem_slave_v2
  import axi_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  parameter int unsigned MEM_SIZE       = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [AXI_STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [AXI_ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready
);

  localparam int unsigned DB     = AXI_STRB_WIDTH;
  localparam int unsigned MEM_AW = $clog2(MEM_SIZE);
  localparam logic [AXI_ADDR_WIDTH-1:0] LANE_MASK = AXI_ADDR_WIDTH'(DB - 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] MEM_LIMIT = AXI_ADDR_WIDTH'(MEM_SIZE);

  logic [7:0] mem [MEM_SIZE];

  // ---------------- write engine ----------------
  w_state_t                  w_state, w_state_n;
  logic [AXI_ADDR_WIDTH-1:0] w_addr, w_addr_n, w_next, w_base;
  logic [7:0]                w_len, w_beat, w_beat_n;
  logic [2:0]                w_size;
  logic [1:0]                w_burst;
  logic                      w_err, w_err_n, w_illegal, w_oor, w_last_beat;
  logic                      aw_hs, w_hs, w_we;
  resp_t                     bresp_n;
  logic [MEM_AW-1:0]         w_idx;

  axi_burst_addr #(.ADDR_W(AXI_ADDR_WIDTH), .DATA_W(AXI_DATA_WIDTH)) u_w_addr (
    .addr     (w_addr),
    .len      (w_len),
    .size     (w_size),
    .burst    (w_burst),
    .next_addr(w_next),
    .illegal  (w_illegal)
  );

  assign aw_hs       = s_axi_awvalid && s_axi_awready;
  assign w_hs        = s_axi_wvalid && s_axi_wready;
  assign w_base      = w_addr & ~LANE_MASK;
  assign w_oor       = w_base >= MEM_LIMIT;
  assign w_idx       = w_base[MEM_AW-1:0];
  assign w_last_beat = (w_beat == w_len);
  assign w_we        = w_hs && !w_illegal && !w_oor;

  always_comb begin
    w_state_n = w_state;
    w_addr_n  = w_addr;
    w_beat_n  = w_beat;
    w_err_n   = w_err;
    bresp_n   = OKAY;
    case (w_state)
      W_IDLE: begin
        if (aw_hs) begin
          w_state_n = W_DATA;
          w_addr_n  = s_axi_awaddr;
          w_beat_n  = 8'd0;
          w_err_n   = 1'b0;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          if ((w_oor && (|s_axi_wstrb)) || (s_axi_wlast != w_last_beat)) w_err_n = 1'b1;
          // Burst length is governed by the beat counter, never by wlast.
          if (w_last_beat) begin
            w_state_n = W_RESP;
          end else begin
            w_addr_n = w_next;
            w_beat_n = 8'(w_beat + 8'd1);
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready) w_state_n = W_IDLE;
      end
      default: w_state_n = W_IDLE;
    endcase
    if (w_state_n == W_RESP) bresp_n = (w_err_n || w_illegal) ? SLVERR : OKAY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state       <= W_IDLE;
      w_addr        <= '0;
      w_beat        <= 8'd0;
      w_err         <= 1'b0;
      w_len         <= 8'd0;
      w_size        <= 3'd0;
      w_burst       <= 2'd0;
      s_axi_bid     <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= OKAY;
    end else begin
      w_state       <= w_state_n;
      w_addr        <= w_addr_n;
      w_beat        <= w_beat_n;
      w_err         <= w_err_n;
      s_axi_awready <= (w_state_n == W_IDLE);
      s_axi_wready  <= (w_state_n == W_DATA);
      s_axi_bvalid  <= (w_state_n == W_RESP);
      s_axi_bresp   <= bresp_n;
      if (aw_hs) begin
        w_len     <= s_axi_awlen;
        w_size    <= s_axi_awsize;
        w_burst   <= s_axi_awburst;
        s_axi_bid <= s_axi_awid;
      end
    end
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < DB; i++) begin
        if (s_axi_wstrb[i]) mem[w_idx + MEM_AW'(i)] <= s_axi_wdata[8*i +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  r_state_t                  r_state, r_state_n;
  logic [AXI_ADDR_WIDTH-1:0] r_addr, r_addr_n, r_next, r_base;
  logic [7:0]                r_len, r_beat, r_beat_n;
  logic [2:0]                r_size;
  logic [1:0]                r_burst;
  logic                      r_illegal, r_oor, ar_hs, r_hs;
  logic [MEM_AW-1:0]         r_idx;
  logic [AXI_DATA_WIDTH-1:0] mem_rword;

  axi_burst_addr #(.ADDR_W(AXI_ADDR_WIDTH), .DATA_W(AXI_DATA_WIDTH)) u_r_addr (
    .addr     (r_addr),
    .len      (r_len),
    .size     (r_size),
    .burst    (r_burst),
    .next_addr(r_next),
    .illegal  (r_illegal)
  );

  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  assign r_hs   = s_axi_rvalid && s_axi_rready;
  assign r_base = r_addr & ~LANE_MASK;
  assign r_oor  = r_base >= MEM_LIMIT;
  assign r_idx  = r_base[MEM_AW-1:0];

  always_comb begin
    mem_rword = '0;
    for (int i = 0; i < DB; i++) mem_rword[8*i +: 8] = mem[r_idx + MEM_AW'(i)];
  end

  always_comb begin
    r_state_n = r_state;
    r_addr_n  = r_addr;
    r_beat_n  = r_beat;
    case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_n = R_FETCH;
          r_addr_n  = s_axi_araddr;
          r_beat_n  = 8'd0;
        end
      end
      R_FETCH: r_state_n = R_DATA;
      R_DATA: begin
        if (r_hs) begin
          if (r_beat == r_len) begin
            r_state_n = R_IDLE;
          end else begin
            r_state_n = R_FETCH;
            r_addr_n  = r_next;
            r_beat_n  = 8'(r_beat + 8'd1);
          end
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= R_IDLE;
      r_addr        <= '0;
      r_beat        <= 8'd0;
      r_len         <= 8'd0;
      r_size        <= 3'd0;
      r_burst       <= 2'd0;
      s_axi_rid     <= '0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= OKAY;
      s_axi_rlast   <= 1'b0;
    end else begin
      r_state       <= r_state_n;
      r_addr        <= r_addr_n;
      r_beat        <= r_beat_n;
      s_axi_arready <= (r_state_n == R_IDLE);
      s_axi_rvalid  <= (r_state_n == R_DATA);
      if (ar_hs) begin
        r_len     <= s_axi_arlen;
        r_size    <= s_axi_arsize;
        r_burst   <= s_axi_arburst;
        s_axi_rid <= s_axi_arid;
      end
      // Beat payload is captured once per fetch and held until the R handshake.
      if (r_state == R_FETCH) begin
        s_axi_rdata <= (r_oor || r_illegal) ? '0 : mem_rword;
        s_axi_rresp <= (r_oor || r_illegal) ? SLVERR : OKAY;
        s_axi_rlast <= (r_beat == r_len);
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_slave_v2.sv
// Randomized self-checking bench for axi_mem_slave_v2 against a byte-array reference model.
module tb_axi_mem_slave_v2;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IW  = 4;
  localparam int SW  = 4;
  localparam int MEM = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] s_axi_awid, s_axi_bid, s_axi_arid, s_axi_rid;
  logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]    s_axi_awlen, s_axi_arlen;
  logic [2:0]    s_axi_awsize, s_axi_arsize;
  logic [1:0]    s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic          s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic          s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic          s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [DW-1:0] s_axi_wdata, s_axi_rdata;
  logic [SW-1:0] s_axi_wstrb;

  always #5 clk = ~clk;

  axi_mem_slave_v2 #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
    .AXI_STRB_WIDTH(SW), .MEM_SIZE(MEM)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_mem   [MEM];
  logic [31:0] wbuf_data [256];
  logic [3:0]  wbuf_strb [256];
  logic [31:0] rd_data   [256];
  logic [1:0]  rd_resp   [256];
  logic [1:0]  wr_bresp;
  time         aw_hs_t, ar_hs_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_illegal(input int burst, input int size, input int len);
    return (burst == 3) || (size > 2) ||
           (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  // Address of the following beat, from the burst rules in plain arithmetic.
  function automatic logic [31:0] m_next(input logic [31:0] a, input int len, input int size,
                                         input int burst);
    longint s, w, low, n, al;
    al = {32'b0, a};
    s  = longint'(1) << size;
    if (burst == 0) return a;
    if (burst == 1) return 32'(((al / s) * s) + s);
    w   = longint'(len + 1) * s;
    low = (al / w) * w;
    n   = al + s;
    if (n == low + w) n = low;
    return 32'(n);
  endfunction

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int bad_last,
                           input int abort_after);
    logic [31:0] a;
    bit          ill, err;
    int          beat, n;
    longint      base;
    a   = addr;
    ill = m_illegal(burst, size, len);
    err = 0;
    @(negedge clk);
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
    s_axi_awsize = 3'(size); s_axi_awburst = 2'(burst); s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 100) begin @(negedge clk); n++; end
    check("aw_accept", 64'(n < 100), 64'd1);
    aw_hs_t = $time;
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    beat = 0; n = 0;
    while (beat <= len && n < 5000) begin
      s_axi_wvalid = ($urandom_range(0, 3) != 0);
      s_axi_wdata  = wbuf_data[beat];
      s_axi_wstrb  = wbuf_strb[beat];
      s_axi_wlast  = (beat == len) != (beat == bad_last);
      if (s_axi_wvalid && s_axi_wready) begin
        base = {32'b0, a} & ~64'd3;
        if (!ill) begin
          for (int i = 0; i < 4; i++)
            if (s_axi_wstrb[i] && base + i < MEM) ref_mem[int'(base) + i] = s_axi_wdata[8*i +: 8];
        end
        if (base >= MEM && |s_axi_wstrb) err = 1;
        if (s_axi_wlast != (beat == len)) err = 1;
        a = m_next(a, len, size, burst);
        beat++;
        if (beat == abort_after) begin
          @(negedge clk);
          s_axi_wvalid = 1'b0;
          return;
        end
      end
      @(negedge clk);
      n++;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    check("w_accept", 64'(n < 5000), 64'd1);
    n = 0;
    s_axi_bready = $urandom_range(0, 1) != 0;
    while (!(s_axi_bvalid && s_axi_bready) && n < 200) begin
      @(negedge clk);
      s_axi_bready = $urandom_range(0, 1) != 0;
      n++;
    end
    check("b_timeout", 64'(n < 200), 64'd1);
    wr_bresp = s_axi_bresp;
    check("bresp", 64'(s_axi_bresp), (err || ill) ? 64'd2 : 64'd0);
    check("bid", 64'(s_axi_bid), 64'(id));
    @(negedge clk);
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input int stall_first);
    logic [31:0] e_data [256];
    logic [1:0]  e_resp [256];
    logic [31:0] a;
    logic [34:0] held_val;
    bit          ill, held;
    int          beat, n, k, stall;
    longint      base;
    a   = addr;
    ill = m_illegal(burst, size, len);
    for (int b = 0; b <= len; b++) begin
      base = {32'b0, a} & ~64'd3;
      if (ill || base >= MEM) begin
        e_data[b] = 32'd0; e_resp[b] = 2'd2;
      end else begin
        e_data[b] = {ref_mem[int'(base) + 3], ref_mem[int'(base) + 2],
                     ref_mem[int'(base) + 1], ref_mem[int'(base)]};
        e_resp[b] = 2'd0;
      end
      a = m_next(a, len, size, burst);
    end
    @(negedge clk);
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len);
    s_axi_arsize = 3'(size); s_axi_arburst = 2'(burst); s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 100) begin @(negedge clk); n++; end
    check("ar_accept", 64'(n < 100), 64'd1);
    ar_hs_t = $time;
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    k = 1;
    while (!s_axi_rvalid && k < 50) begin @(negedge clk); k++; end
    check("ar_to_rvalid", 64'(k), 64'd2);
    beat = 0; n = 0; held = 0; stall = stall_first; held_val = '0;
    while (beat <= len && n < 5000) begin
      if (s_axi_rvalid) begin
        if (held) check("r_hold", 64'({s_axi_rdata, s_axi_rresp, s_axi_rlast}), 64'(held_val));
        if (beat == 0 && stall > 0) begin
          s_axi_rready = 1'b0;
          stall--;
        end else begin
          s_axi_rready = $urandom_range(0, 3) != 0;
        end
        if (s_axi_rready) begin
          check("rdata", 64'(s_axi_rdata), 64'(e_data[beat]));
          check("rresp", 64'(s_axi_rresp), 64'(e_resp[beat]));
          check("rlast", 64'(s_axi_rlast), 64'(beat == len));
          check("rid", 64'(s_axi_rid), 64'(id));
          rd_data[beat] = s_axi_rdata;
          rd_resp[beat] = s_axi_rresp;
          beat++;
          held = 0;
        end else begin
          held = 1;
          held_val = {s_axi_rdata, s_axi_rresp, s_axi_rlast};
        end
      end else begin
        s_axi_rready = $urandom_range(0, 1) != 0;
        held = 0;
      end
      @(negedge clk);
      n++;
    end
    s_axi_rready = 1'b0;
    check("r_done", 64'(n < 5000), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check(tag, 64'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid,
                    s_axi_rlast, s_axi_bresp, s_axi_rresp, s_axi_bid, s_axi_rid, s_axi_rdata}),
          64'd0);
  endtask

  initial begin
    int burst, size, len, bad_last;
    logic [31:0] addr;
    rst = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
    s_axi_awburst = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_outputs");
    rst = 1'b0;
    @(negedge clk);
    check("awready_after_reset", 64'(s_axi_awready), 64'd1);
    check("arready_after_reset", 64'(s_axi_arready), 64'd1);

    // Populate the whole RAM so every later read has a defined expectation.
    for (int blk = 0; blk < 4; blk++) begin
      for (int b = 0; b < 256; b++) begin wbuf_data[b] = $urandom; wbuf_strb[b] = 4'hF; end
      axi_write(4'(blk), 32'(blk * 1024), 255, 2, 1, -1, -1);
    end
    axi_read(4'd5, 32'h0000_0400, 255, 2, 1, 0);

    wbuf_data[0] = 32'hDEAD_BEEF; wbuf_strb[0] = 4'hF;
    axi_write(4'd1, 32'h10, 0, 2, 1, -1, -1);
    check("single_bresp", 64'(wr_bresp), 64'd0);
    axi_read(4'd2, 32'h10, 0, 2, 1, 0);
    check("single_rdata", 64'(rd_data[0]), 64'hDEAD_BEEF);

    for (int b = 0; b < 4; b++) begin wbuf_data[b] = 32'(b + 1); wbuf_strb[b] = 4'hF; end
    axi_write(4'd3, 32'h100, 3, 2, 1, -1, -1);
    axi_read(4'd3, 32'h100, 3, 2, 1, 0);
    for (int b = 0; b < 4; b++) check("incr_data", 64'(rd_data[b]), 64'(b + 1));

    wbuf_data[0] = 32'hA0A0_A0A0; wbuf_data[1] = 32'hB1B1_B1B1;
    wbuf_data[2] = 32'hC2C2_C2C2; wbuf_data[3] = 32'hD3D3_D3D3;
    axi_write(4'd4, 32'h38, 3, 2, 2, -1, -1);
    axi_read(4'd4, 32'h30, 3, 2, 1, 0);
    check("wrap_0x30", 64'(rd_data[0]), 64'hC2C2_C2C2);
    check("wrap_0x34", 64'(rd_data[1]), 64'hD3D3_D3D3);
    check("wrap_0x38", 64'(rd_data[2]), 64'hA0A0_A0A0);
    check("wrap_0x3c", 64'(rd_data[3]), 64'hB1B1_B1B1);
    axi_read(4'd4, 32'h38, 3, 2, 2, 0);
    check("wrap_rd_beat0", 64'(rd_data[0]), 64'hA0A0_A0A0);
    check("wrap_rd_beat2", 64'(rd_data[2]), 64'hC2C2_C2C2);

    wbuf_data[0] = 32'h0000_AB00; wbuf_strb[0] = 4'b0010;
    axi_write(4'd6, 32'h21, 0, 0, 1, -1, -1);
    axi_read(4'd6, 32'h20, 0, 2, 1, 0);
    check("narrow_byte21", 64'(rd_data[0][15:8]), 64'hAB);

    wbuf_data[0] = 32'h1111_2222; wbuf_data[1] = 32'h3333_4444;
    wbuf_strb[0] = 4'hF; wbuf_strb[1] = 4'hF;
    axi_write(4'd7, 32'(MEM - 4), 1, 2, 1, -1, -1);
    check("oor_bresp", 64'(wr_bresp), 64'd2);
    axi_read(4'd7, 32'(MEM - 4), 1, 2, 1, 0);
    check("oor_beat0", 64'({rd_data[0], rd_resp[0]}), {30'd0, 32'h1111_2222, 2'd0});
    check("oor_beat1", 64'({rd_data[1], rd_resp[1]}), {30'd0, 32'h0, 2'd2});

    wbuf_data[0] = 32'h5555_5555; wbuf_strb[0] = 4'hF;
    axi_write(4'd8, 32'h200, 0, 2, 3, -1, -1);
    check("bad_burst_bresp", 64'(wr_bresp), 64'd2);
    axi_read(4'd8, 32'h200, 0, 2, 1, 0);

    // Write and read engines accepting addresses on the same edge.
    for (int b = 0; b < 4; b++) begin wbuf_data[b] = $urandom; wbuf_strb[b] = 4'hF; end
    fork
      axi_write(4'd9, 32'h600, 3, 2, 1, -1, -1);
      axi_read(4'd10, 32'h800, 3, 2, 1, 0);
    join
    check("same_cycle_hs", 64'(aw_hs_t), 64'(ar_hs_t));

    axi_read(4'd11, 32'h600, 1, 2, 1, 5);

    for (int b = 0; b < 8; b++) begin wbuf_data[b] = $urandom; wbuf_strb[b] = 4'hF; end
    axi_write(4'd12, 32'h300, 7, 2, 1, -1, 3);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_burst_reset");
    s_axi_wvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("awready_post_reset", 64'(s_axi_awready), 64'd1);
    axi_read(4'd12, 32'h300, 7, 2, 1, 0);

    for (int t = 0; t < 60; t++) begin
      int r;
      r = $urandom_range(0, 15);
      burst = (r < 2) ? 0 : (r < 10) ? 1 : (r < 15) ? 2 : 3;
      size  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      if (burst == 2) begin
        r = $urandom_range(0, 8);
        len = (r == 0) ? 2 : (r < 3) ? 1 : (r < 5) ? 3 : (r < 7) ? 7 : 15;
      end else begin
        len = $urandom_range(0, 7);
      end
      addr = 32'($urandom_range(0, MEM + 63));
      addr = addr & ~((32'd1 << size) - 32'd1);
      bad_last = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
      for (int b = 0; b <= len; b++) begin
        wbuf_data[b] = $urandom; wbuf_strb[b] = 4'($urandom_range(0, 15));
      end
      axi_write(4'($urandom_range(0, 15)), addr, len, size, burst, bad_last, -1);
      axi_read(4'($urandom_range(0, 15)), addr, len, size, burst, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=0x%0h exp=0x%0h", checks, 0);
    $fatal(1, "timeout");
  end

endmodule
